// File: rtl/param_alu_accum_if.sv
// Command/result bundle for param_alu_accum: command handshake, operands, result handshake and status flags.
// Latency: none (wires only).
// Backpressure: carried by in_ready (from the ALU) and out_ready (from the consumer).
//
// Signals (direction seen from the ALU, i.e. the slave modport):
//   clr        in   synchronous clear
//   in_valid   in   command valid
//   in_ready   out  command accepted when in_valid && in_ready at an edge
//   op         in   000 ADD, 001 SUB, 010 ACC, 011 MUL, 100 CLR, others NOP
//   a, b       in   unsigned operands
//   out_valid  out  result valid, held until out_ready
//   out_ready  in   consumer ready
//   result     out  result/accumulator register
//   carry      out  carry or borrow of the last operation
//   ovf_sticky out  set on any carry/borrow, cleared by clr or reset
//   busy       out  multiply in progress
interface param_alu_accum_if #(
    parameter int WIDTH = 8
);
    logic             clr;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             ovf_sticky;
    logic             busy;

    modport slave (
        input  clr, in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, carry, ovf_sticky, busy
    );

    modport master (
        output clr, in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, carry, ovf_sticky, busy
    );
endinterface

// File: rtl/param_alu_accum.sv
// WIDTH-bit ALU (ADD/SUB/ACC/shift-add MUL/CLR) with persistent result register, carry and sticky overflow.
// Latency: non-MUL result valid the cycle after accept; MUL result written WIDTH edges after accept.
// Backpressure: one command in flight; in_ready only in IDLE, result/out_valid hold in DONE until out_ready.
//
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset (discards any operation in flight)
//   bus    slave modport of param_alu_accum_if (handshakes, operands, result, flags)
module param_alu_accum #(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    param_alu_accum_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_ACC = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_CLR = 3'b100;

    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    logic [1:0]         state_q,  state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carry_q,  carry_d;
    logic               ovf_q,    ovf_d;
    // Multiplier datapath: multiplicand shifts left, multiplier shifts right
    // so its LSB is always the bit being examined this cycle.
    logic [2*WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] prod_q,   prod_d;
    logic [CW-1:0]      cnt_q,    cnt_d;

    logic               accept;
    logic [WIDTH:0]     sum_add;
    logic [WIDTH:0]     diff_sub;
    logic [WIDTH:0]     sum_acc;
    logic [2*WIDTH-1:0] prod_step;
    logic               mul_hi;

    // clr wins over a same-cycle command even though in_ready may read 1.
    assign accept    = bus.in_valid && (state_q == ST_IDLE) && !bus.clr;

    assign sum_add   = {1'b0, bus.a} + {1'b0, bus.b};
    // Bit WIDTH of the extended difference is exactly the a<b borrow.
    assign diff_sub  = {1'b0, bus.a} - {1'b0, bus.b};
    assign sum_acc   = {1'b0, result_q} + {1'b0, bus.a};
    assign prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);
    assign mul_hi    = |prod_step[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;

        if (bus.clr) begin
            state_d  = ST_IDLE;
            result_d = '0;
            carry_d  = 1'b0;
            ovf_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_d = ST_DONE;
                        case (bus.op)
                            OP_ADD: begin
                                result_d = (SATURATE && sum_add[WIDTH]) ? ALL_ONES : sum_add[WIDTH-1:0];
                                carry_d  = sum_add[WIDTH];
                                ovf_d    = ovf_q | sum_add[WIDTH];
                            end
                            OP_SUB: begin
                                result_d = (SATURATE && diff_sub[WIDTH]) ? '0 : diff_sub[WIDTH-1:0];
                                carry_d  = diff_sub[WIDTH];
                                ovf_d    = ovf_q | diff_sub[WIDTH];
                            end
                            OP_ACC: begin
                                result_d = (SATURATE && sum_acc[WIDTH]) ? ALL_ONES : sum_acc[WIDTH-1:0];
                                carry_d  = sum_acc[WIDTH];
                                ovf_d    = ovf_q | sum_acc[WIDTH];
                            end
                            OP_MUL: begin
                                // Operands are copied here; a/b are not looked at again.
                                state_d  = ST_BUSY;
                                mcand_d  = {{WIDTH{1'b0}}, bus.a};
                                mplier_d = bus.b;
                                prod_d   = '0;
                                cnt_d    = '0;
                            end
                            OP_CLR: begin
                                result_d = '0;
                                carry_d  = 1'b0;
                            end
                            default: begin
                                carry_d  = 1'b0;
                            end
                        endcase
                    end
                end

                ST_BUSY: begin
                    prod_d   = prod_step;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 1'b1;
                    // Last multiplier bit: publish the product only now, so the
                    // visible result stays at its old value while busy.
                    if (cnt_q == CNT_LAST) begin
                        state_d  = ST_DONE;
                        result_d = (SATURATE && mul_hi) ? ALL_ONES : prod_step[WIDTH-1:0];
                        carry_d  = mul_hi;
                        ovf_d    = ovf_q | mul_hi;
                    end
                end

                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_d = ST_IDLE;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.in_ready   = (state_q == ST_IDLE);
    assign bus.out_valid  = (state_q == ST_DONE);
    assign bus.busy       = (state_q == ST_BUSY);
    assign bus.result     = result_q;
    assign bus.carry      = carry_q;
    assign bus.ovf_sticky = ovf_q;
endmodule

// File: tb/tb_param_alu_accum.sv
// Directed bench for param_alu_accum at WIDTH=8, one wrapping and one saturating instance on shared stimulus.
// Latency: n/a.
// Backpressure: out_ready driven directly by the directed steps.
module tb_param_alu_accum;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_ACC = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic       in_valid;
    logic       out_ready;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    param_alu_accum_if #(.WIDTH(8)) bw ();
    param_alu_accum_if #(.WIDTH(8)) bs ();

    assign bw.clr = clr;       assign bs.clr = clr;
    assign bw.in_valid = in_valid; assign bs.in_valid = in_valid;
    assign bw.out_ready = out_ready; assign bs.out_ready = out_ready;
    assign bw.op = op;         assign bs.op = op;
    assign bw.a = a;           assign bs.a = a;
    assign bw.b = b;           assign bs.b = b;

    param_alu_accum #(.WIDTH(8), .SATURATE(1'b0)) dut_wrap (.clk(clk), .rst_n(rst_n), .bus(bw));
    param_alu_accum #(.WIDTH(8), .SATURATE(1'b1)) dut_sat  (.clk(clk), .rst_n(rst_n), .bus(bs));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        op = o; a = x; b = y; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        int nb;
        int stall_err;
        rst_n = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = 3'b000; a = 8'd0; b = 8'd0;
        #2 rst_n = 1'b0;
        step(); step();

        // reset state
        chk("rst in_ready",  bw.in_ready, 1);
        chk("rst out_valid", bw.out_valid, 0);
        chk("rst busy",      bw.busy, 0);
        chk("rst result",    bw.result, 0);
        chk("rst carry",     bw.carry, 0);
        chk("rst ovf",       bw.ovf_sticky, 0);
        rst_n = 1'b1;
        step();

        // 1: plain ADD
        send(OP_ADD, 8'd100, 8'd27);
        chk("add out_valid", bw.out_valid, 1);
        chk("add result",    bw.result, 127);
        chk("add carry",     bw.carry, 0);
        chk("add in_ready",  bw.in_ready, 0);
        step();
        chk("add idle in_ready",  bw.in_ready, 1);
        chk("add idle out_valid", bw.out_valid, 0);

        // 2: ADD overflow and SUB borrow
        send(OP_ADD, 8'd200, 8'd100);
        chk("addov wrap result", bw.result, 44);
        chk("addov sat result",  bs.result, 255);
        chk("addov carry",       bw.carry, 1);
        chk("addov ovf",         bw.ovf_sticky, 1);
        chk("addov sat ovf",     bs.ovf_sticky, 1);
        step();
        send(OP_SUB, 8'd5, 8'd9);
        chk("sub wrap result", bw.result, 252);
        chk("sub sat result",  bs.result, 0);
        chk("sub borrow",      bw.carry, 1);
        chk("sub sat borrow",  bs.carry, 1);
        step();

        // 3: MUL 13*11, busy for exactly WIDTH cycles
        send(OP_MUL, 8'd13, 8'd11);
        nb = 0;
        for (int i = 0; i < 8; i++) begin
            if (bw.busy === 1'b1) nb++;
            if (i == 4) chk("mul result held while busy", bw.result, 252);
            step();
        end
        chk("mul busy cycles", nb, 8);
        chk("mul out_valid",   bw.out_valid, 1);
        chk("mul result",      bw.result, 143);
        chk("mul carry",       bw.carry, 0);
        chk("mul sat result",  bs.result, 143);
        step();
        chk("mul idle", bw.in_ready, 1);

        // MUL 16*16 overflows into the upper half
        send(OP_MUL, 8'd16, 8'd16);
        for (int i = 0; i < 8; i++) step();
        chk("mul16 out_valid",   bw.out_valid, 1);
        chk("mul16 wrap result", bw.result, 0);
        chk("mul16 sat result",  bs.result, 255);
        chk("mul16 carry",       bw.carry, 1);
        step();

        // 4: ACC x4 with 5-cycle stalls each
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr result", bw.result, 0);
        chk("clr ovf",    bw.ovf_sticky, 0);
        chk("clr carry",  bw.carry, 0);
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            send(OP_ACC, 8'd3, 8'd0);
            chk("acc result", bw.result, 3 * k);
            stall_err = 0;
            in_valid = 1'b1;   // offered but must not be taken while stalled
            for (int s = 0; s < 5; s++) begin
                step();
                if (bw.result !== 8'(3 * k) || bw.out_valid !== 1'b1 || bw.in_ready !== 1'b0)
                    stall_err++;
            end
            in_valid = 1'b0;
            chk("acc stall stable", stall_err, 0);
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
        chk("acc sat final", bs.result, 12);
        out_ready = 1'b1;

        // 5: clr on the 4th BUSY cycle with a command offered
        send(OP_ADD, 8'd200, 8'd100);
        step();
        chk("pre-abort ovf", bw.ovf_sticky, 1);
        send(OP_MUL, 8'd13, 8'd11);
        step(); step(); step();
        chk("abort in busy", bw.busy, 1);
        clr = 1'b1; in_valid = 1'b1; op = OP_ADD; a = 8'd1; b = 8'd1;
        step();
        clr = 1'b0; in_valid = 1'b0;
        chk("abort in_ready",  bw.in_ready, 1);
        chk("abort busy",      bw.busy, 0);
        chk("abort out_valid", bw.out_valid, 0);
        chk("abort result",    bw.result, 0);
        chk("abort ovf",       bw.ovf_sticky, 0);
        step(); step();
        chk("abort no accept out_valid", bw.out_valid, 0);
        chk("abort no accept result",    bw.result, 0);

        // 6: async reset in DONE
        out_ready = 1'b0;
        send(OP_ADD, 8'd200, 8'd100);
        chk("pre-reset out_valid", bw.out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst out_valid", bw.out_valid, 0);
        chk("async rst in_ready",  bw.in_ready, 1);
        chk("async rst result",    bw.result, 0);
        chk("async rst carry",     bw.carry, 0);
        chk("async rst ovf",       bw.ovf_sticky, 0);
        chk("async rst sat result", bs.result, 0);
        step(); step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        send(OP_ADD, 8'd100, 8'd27);
        chk("post-rst out_valid", bw.out_valid, 1);
        chk("post-rst result",    bw.result, 127);
        chk("post-rst carry",     bw.carry, 0);
        step();
        chk("post-rst idle", bw.in_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
